spi_host_bridge: RTL and testbench

- Host-side front end that sits directly upstream of the SPI master/slave integration.
- Buffers host TX bytes in a FIFO and hands them one at a time to the SPI master: load the byte, pulse start, wait for done.
- Collects each exchanged byte returned by the master into an RX FIFO for the host.
- Latches CPOL/CPHA/slave-select per transfer and guards each transfer with a watchdog.

---
 rtl/spi_host_bridge.sv | 136 +++++++++++++
 tb/tb_spi_host_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_bridge.sv
// Host-side bridge in front of an SPI master: buffers TX bytes, sequences
// one load/start/done exchange per byte with a watchdog, and queues replies in an RX FIFO.
module spi_host_bridge #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       cfg_cpol,
  input  logic       cfg_cpha,
  input  logic [1:0] cfg_select,
  output logic       spi_cpol,
  output logic       spi_cpha,
  output logic [1:0] spi_select,
  output logic       spi_load,
  output logic [7:0] spi_data_out,
  output logic       spi_start,
  input  logic       spi_done,
  input  logic [7:0] spi_data_in,
  output logic       busy,
  output logic       err_timeout
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;

  logic [2:0]    state;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW:0]   tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0] wd;
  logic [CW-1:0] wd_next;
  logic [7:0]    rx_hold;
  logic [7:0]    data_q;
  logic [7:0]    tx_head;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (state == S_LOAD);
  assign rx_valid = !rx_empty;
  assign rx_push  = (state == S_STORE);
  assign rx_pop   = rx_valid && rx_ready;

  assign tx_head      = tx_mem[tx_rptr[AW-1:0]];
  assign rx_data      = rx_valid ? rx_mem[rx_rptr[AW-1:0]] : 8'h00;
  assign spi_data_out = (state == S_LOAD) ? tx_head : data_q;
  assign spi_load     = (state == S_LOAD);
  assign spi_start    = (state == S_START);
  assign busy         = (state != S_IDLE);
  assign wd_next      = wd + 1'b1;

  // NOTE: the storage arrays are not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // NOTE: every state register uses <= so all branches see the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wd          <= '0;
      rx_hold     <= '0;
      data_q      <= '0;
      spi_cpol    <= 1'b0;
      spi_cpha    <= 1'b0;
      spi_select  <= 2'b00;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Only one byte is ever in flight, so a free RX slot now is a free slot at STORE.
          if (!tx_empty && !rx_full) state <= S_LOAD;
        end
        S_LOAD: begin
          data_q     <= tx_head;
          spi_cpol   <= cfg_cpol;
          spi_cpha   <= cfg_cpha;
          spi_select <= cfg_select;
          state      <= S_START;
        end
        S_START: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wd <= wd_next;
          if (spi_done) begin
            rx_hold <= spi_data_in;
            state   <= S_STORE;
          end else if (wd_next == CW'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_STORE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_bridge.sv
// Randomized scoreboard bench for spi_host_bridge: stimulus queues expected loads and
// replies, a monitor checks every cycle, and a model SPI master answers with the inverted byte.
module tb_spi_host_bridge;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;
  localparam int CW      = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       cfg_cpol, cfg_cpha;
  logic [1:0] cfg_select;
  logic       spi_cpol, spi_cpha;
  logic [1:0] spi_select;
  logic       spi_load;
  logic [7:0] spi_data_out;
  logic       spi_start;
  logic       spi_done;
  logic [7:0] spi_data_in;
  logic       busy;
  logic       err_timeout;

  spi_host_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_select(cfg_select),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_select(spi_select),
    .spi_load(spi_load), .spi_data_out(spi_data_out), .spi_start(spi_start),
    .spi_done(spi_done), .spi_data_in(spi_data_in),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mute;
    int unsigned delay;
    int unsigned len;
  } plan_t;

  plan_t      plan_q[$];
  logic [7:0] exp_load[$];
  logic [7:0] exp_rx[$];

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         tx_cnt      = 0;
  int         n_loads     = 0;
  int         n_starts    = 0;
  int         last_start_cyc = 0;
  logic [7:0] held_data   = 8'h00;
  logic [3:0] held_cfg    = 4'h0;
  bit         rand_done   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: TX occupancy, load ordering, held outputs, and RX scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("tx_ready", tx_ready, tx_cnt < DEPTH);
      check("cfg_hold", {spi_cpol, spi_cpha, spi_select}, held_cfg);
      if (spi_load) begin
        n_loads++;
        if (exp_load.size() == 0) check("spurious_load", 1, 0);
        else begin
          held_data = exp_load.pop_front();
          check("load_byte", spi_data_out, held_data);
        end
        held_cfg = {cfg_cpol, cfg_cpha, cfg_select};
      end else begin
        check("data_hold", spi_data_out, held_data);
      end
      if (spi_start) n_starts++;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) check("spurious_rx", rx_data, 32'hFFFF_FFFF);
        else check("rx_byte", rx_data, exp_rx.pop_front());
      end
      if (tx_valid && tx_ready) tx_cnt++;
      if (spi_load) tx_cnt--;
    end
  end

  // Model SPI master: returns ~byte after a planned delay, done held for 1..3 cycles.
  initial begin
    logic [7:0] m_byte;
    plan_t      p;
    m_byte = 8'h00;
    spi_done = 1'b0;
    spi_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && spi_load) m_byte = spi_data_out;
      if (!reset && spi_start) begin
        last_start_cyc = cyc;
        if (plan_q.size() == 0) p = '{mute: 1'b1, delay: 0, len: 0};
        else p = plan_q.pop_front();
        if (!p.mute) begin
          repeat (p.delay) @(posedge clk);
          #1;
          spi_done = 1'b1;
          spi_data_in = ~m_byte;
          repeat (p.len) @(posedge clk);
          #1;
          spi_done = 1'b0;
          spi_data_in = 8'($urandom);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit mute, input int unsigned delay,
                      input int unsigned len);
    bit ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("tx_accept", ok, 1);
    if (ok) begin
      exp_load.push_back(b);
      plan_q.push_back('{mute: mute, delay: delay, len: len});
      if (!mute) exp_rx.push_back(~b);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic rnd_send(input logic [7:0] b);
    send(b, 1'b0, $urandom_range(1, 12), $urandom_range(1, 3));
  endtask

  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    rx_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_rx.size() == 0 && exp_load.size() == 0 && !busy && !rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", ok, 1);
    check("drain_rx_left", exp_rx.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_ready"}, tx_ready, 1);
    check({name, "_outs"}, {rx_valid, rx_data, spi_load, spi_start, spi_data_out,
                            spi_cpol, spi_cpha, spi_select, busy, err_timeout}, 0);
  endtask

  task automatic flush_model();
    exp_load.delete();
    exp_rx.delete();
    plan_q.delete();
    tx_cnt    = 0;
    held_data = 8'h00;
    held_cfg  = 4'h0;
  endtask

  initial begin
    int l0, s0;
    bit ok;
    reset = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_ready = 1'b0;
    cfg_cpol = 1'b0;
    cfg_cpha = 1'b0;
    cfg_select = 2'd0;

    // Power-on reset
    #2 reset = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single byte: FF out, 00 back after 10 cycles
    cfg_select = 2'd1;
    l0 = n_loads;
    s0 = n_starts;
    send(8'hFF, 1'b0, 10, 1);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("single_rx_valid", ok, 1);
    check("single_rx_data", rx_data, 8'h00);
    check("single_busy_after_store", busy, 0);
    check("single_loads", n_loads - l0, 1);
    check("single_starts", n_starts - s0, 1);
    @(posedge clk);
    #1;
    drain();

    // Burst ordering
    rnd_send(8'hA5);
    rnd_send(8'h3C);
    rnd_send(8'hF0);
    rnd_send(8'h0F);
    drain();

    // Config latching across a mid-transfer cfg change
    cfg_cpol = 1'b1;
    cfg_cpha = 1'b1;
    cfg_select = 2'd2;
    send(8'h96, 1'b0, 10, 1);
    wait_start("cfg_start1");
    @(posedge clk);
    #1;
    cfg_cpol = 1'b0;
    cfg_cpha = 1'b0;
    cfg_select = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cfg_busy_wait", busy, 1);
    check("cfg_held_select", spi_select, 2);
    check("cfg_held_pol_pha", {spi_cpol, spi_cpha}, 2'b11);
    @(posedge clk);
    #1;
    send(8'h69, 1'b0, 4, 1);
    wait_start("cfg_start2");
    check("cfg_next_select", spi_select, 3);
    check("cfg_next_pol_pha", {spi_cpol, spi_cpha}, 2'b00);
    @(posedge clk);
    #1;
    drain();

    // RX backpressure: 6 bytes, only DEPTH transfers may run
    rx_ready = 1'b0;
    l0 = n_loads;
    for (int i = 0; i < 6; i++) rnd_send(8'($urandom));
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("bp_loads", n_loads - l0, DEPTH);
    check("bp_busy", busy, 0);
    check("bp_rx_valid", rx_valid, 1);
    @(posedge clk);
    #1;
    rnd_send(8'h5E);
    rnd_send(8'hE5);
    fork
      rnd_send(8'hE7);
      begin
        repeat (3) @(negedge clk);
        check("bp_tx_full", tx_ready, 0);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with rx_ready toggling
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          cfg_cpol = 1'($urandom);
          cfg_cpha = 1'($urandom);
          cfg_select = 2'($urandom);
          rnd_send(8'($urandom));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rx_ready = ($urandom_range(0, 3) != 0);
        end
        rx_ready = 1'b1;
      end
    join
    drain();

    // Watchdog abort, then the next byte proceeds
    check("err_before_timeout", err_timeout, 0);
    send(8'h11, 1'b1, 0, 0);
    send(8'h22, 1'b0, 5, 1);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        ok = 1'b1;
        break;
      end
    end
    check("timeout_seen", ok, 1);
    // WAIT is entered on the edge after the START cycle
    check("timeout_cycles", cyc - (last_start_cyc + 1), TIMEOUT);
    @(posedge clk);
    #1;
    drain();
    check("err_sticky", err_timeout, 1);

    // Asynchronous reset in WAIT with two bytes still queued
    send(8'h33, 1'b1, 0, 0);
    send(8'h44, 1'b0, 3, 1);
    send(8'h55, 1'b0, 3, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_tx_queued", tx_cnt, 2);
    #2;
    reset = 1'b1;
    flush_model();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    rnd_send(8'hAA);
    drain();
    check("err_after_reset", err_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
